// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder
// Buffers signed audio samples in a small FIFO and releases one sample per
// programmable sample period. Each released sample becomes an offset-binary
// duty value for a downstream PWM stage. An empty buffer at a sample tick
// raises a sticky underrun flag, and the duty value is left unchanged.
module audio_sample_feeder #(
  parameter int BIT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          divider,
  input  logic                          s_valid,
  input  logic [BIT_WIDTH-1:0]          s_data,
  output logic                          s_ready,
  output logic [BIT_WIDTH:0]            duty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]      LEVEL_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]      LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]    PTR_ONE    = ADDR_W'(1);
  localparam logic [DIV_WIDTH-1:0] COUNT_ONE  = DIV_WIDTH'(1);
  localparam logic [BIT_WIDTH:0]   MIDPOINT   = {2'b01, {(BIT_WIDTH-1){1'b0}}};

  logic [BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    r_wrPtr;
  logic [ADDR_W-1:0]    r_rdPtr;
  logic [ADDR_W:0]      r_level;
  logic [DIV_WIDTH-1:0] r_count;
  logic [BIT_WIDTH:0]   r_duty;
  logic                 r_underrun;

  logic                 w_tick;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [BIT_WIDTH-1:0] w_head;
  logic [BIT_WIDTH:0]   w_headDuty;

  // Tick, handshake and conversion decode. The tick uses >= so that a divider
  // lowered below the running count fires at once instead of waiting for wrap.
  always_comb begin
    w_empty    = (r_level == '0);
    s_ready    = (r_level != LEVEL_FULL);
    w_tick     = enable && (r_count >= divider);
    w_push     = s_valid && s_ready;
    w_pop      = w_tick && !w_empty;
    w_head     = r_mem[r_rdPtr];
    w_headDuty = {1'b0, ~w_head[BIT_WIDTH-1], w_head[BIT_WIDTH-2:0]};
  end

  // Sample storage; no reset, since entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves level as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LEVEL_ONE;
        2'b01:   r_level <= r_level - LEVEL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sample-period counter, parked at zero while playback is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!enable || w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + COUNT_ONE;
    end
  end

  // Duty register: midpoint while stopped, new sample on a pop, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= MIDPOINT;
    end else if (!enable) begin
      r_duty <= MIDPOINT;
    end else if (w_pop) begin
      r_duty <= w_headDuty;
    end
  end

  // Sticky underrun flag; a new underrun outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_tick && w_empty) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  assign duty     = r_duty;
  assign level    = r_level;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder
// Directed scenarios followed by a random phase, all compared every cycle
// against a queue-based behavioural model of the sample feeder.
module tb_audio_sample_feeder;

  localparam int BW = 8;
  localparam int FD = 16;
  localparam int DW = 16;
  localparam logic [BW:0] MID = 9'h080;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] divider;
  logic          s_valid;
  logic [BW-1:0] s_data;
  logic          s_ready;
  logic [BW:0]   duty;
  logic [4:0]    level;
  logic          underrun;
  logic          underrun_clr;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: the buffered samples, cycles elapsed in the
  // current sample period, the expected duty and the expected flag.
  logic [BW-1:0] q[$];
  int            mPhase;
  logic [BW:0]   mDuty;
  logic          mUnder;

  audio_sample_feeder #(.BIT_WIDTH(BW), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .divider      (divider),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .duty         (duty),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".duty"},     32'(duty),     32'(mDuty));
    checkOutput({tag, ".level"},    32'(level),    32'(q.size()));
    checkOutput({tag, ".s_ready"},  32'(s_ready),  32'(q.size() != FD));
    checkOutput({tag, ".underrun"}, 32'(underrun), 32'(mUnder));
  endtask

  task automatic modelReset();
    q.delete();
    mPhase = 0;
    mDuty  = MID;
    mUnder = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [BW-1:0] d,
                               input logic en, input logic clr);
    s_valid      = v;
    s_data       = d;
    enable       = en;
    underrun_clr = clr;
  endtask

  // Advance one clock: predict the result of the coming edge from the
  // current inputs, then compare the DUT just after the edge.
  task automatic clockStep(input string tag);
    logic          tick;
    logic          wasEmpty;
    logic          pushOk;
    logic [BW-1:0] head;
    tick     = enable && (mPhase >= int'(divider));
    wasEmpty = (q.size() == 0);
    pushOk   = s_valid && (q.size() != FD);
    if (!enable) begin
      mDuty = MID;
    end else if (tick && !wasEmpty) begin
      head  = q.pop_front();
      mDuty = {1'b0, head ^ 8'h80};
    end
    if (tick && wasEmpty) mUnder = 1'b1;
    else if (underrun_clr) mUnder = 1'b0;
    if (pushOk) q.push_back(s_data);
    mPhase = (!enable || tick) ? 0 : mPhase + 1;
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [BW-1:0] conv[3];
    conv[0] = 8'h80;
    conv[1] = 8'h00;
    conv[2] = 8'h7F;

    // Reset held with enable low, checked before any clock edge matters.
    rst_n   = 1'b0;
    divider = 16'd3;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    modelReset();
    #12;
    checkAll("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    clockStep("reset_release");
    clockStep("reset_idle");

    // Conversion: 8'h80 -> 0, 8'h00 -> 128, 8'h7F -> 255, four cycles apart.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, conv[i], 1'b0, 1'b0);
      clockStep("conv_push");
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) clockStep("conv_run");
    checkOutput("conv_final_duty", 32'(duty), 32'h0FF);

    // Fill with enable low: 17 offers, only 16 accepted, then drain in order.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    clockStep("fill_clr");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      clockStep("fill_push");
    end
    checkOutput("fill_full_level", 32'(level), 32'd16);
    checkOutput("fill_full_ready", 32'(s_ready), 32'd0);
    divider = 16'd0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) clockStep("fill_drain");

    // Underrun: one sample, divider=1; then clear with and without a tick.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    clockStep("under_prep");
    divider = 16'd1;
    applyStimulus(1'b1, 8'h35, 1'b0, 1'b0);
    clockStep("under_push");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) clockStep("under_run");
    checkOutput("under_hold_duty", 32'(duty), 32'h0B5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      clockStep("under_clr");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    clockStep("under_clr_idle");

    // Simultaneous push/pop: level 5, push exactly on tick cycles.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      clockStep("pp_fill");
    end
    divider = 16'd2;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(mPhase >= 2, 8'(8'h40 + i), 1'b1, 1'b0);
      clockStep("pp_run");
    end
    checkOutput("pp_level", 32'(level), 32'd5);

    // Mid-operation divider drop from 100 to 2 while the count sits at 50.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    clockStep("mid_stop");
    divider = 16'd100;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) clockStep("mid_count");
    divider = 16'd2;
    clockStep("mid_drop");
    checkOutput("mid_drop_level", 32'(level), 32'd4);
    clockStep("mid_after");

    // Asynchronous reset mid-stream, between clock edges.
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    clockStep("async_release");

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 40) == 0) divider = 16'($urandom_range(0, 5));
      applyStimulus(($urandom % 3) != 0, 8'($urandom),
                    ($urandom % 8) != 0, ($urandom % 6) == 0);
      clockStep("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, giving the sample width and the PWM resolution.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the sample buffer entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 16, giving the sample-rate divider width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run playback.
REQ-007 The block SHALL have port divider, input, DIV_WIDTH bits: sample period minus one, in clk cycles.
REQ-008 The block SHALL have port s_valid, input, 1 bit: a sample is offered.
REQ-009 The block SHALL have port s_data, input, BIT_WIDTH bits: signed two's-complement sample.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the FIFO can accept a sample.
REQ-011 The block SHALL have port duty, output, BIT_WIDTH+1 bits: registered duty value that feeds the PWM stage.
REQ-012 The block SHALL have port level, output, log2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port underrun, output, 1 bit: sticky underrun flag.
REQ-014 The block SHALL have port underrun_clr, input, 1 bit: clears underrun.

Function
REQ-015 A push SHALL occur on a cycle with s_valid && s_ready; s_ready = (level != FIFO_DEPTH), combinational from state only.
REQ-016 The FIFO SHALL be first-in first-out with wrap-around read/write pointers; level counts 0..FIFO_DEPTH inclusive.
REQ-017 The tick counter SHALL be held at 0 while enable=0; with enable=1 it increments each cycle.
REQ-018 A tick SHALL fire on the cycle when counter >= divider, and the counter SHALL return to 0 on that cycle; the period is divider+1 cycles, and divider=0 ticks every cycle.
REQ-019 On a tick with level>0 the head sample SHALL pop, and duty SHALL become {1'b0, s_data with MSB inverted} (offset binary, range 0..2^BIT_WIDTH-1) on the next edge.
REQ-020 On a tick with level=0, duty SHALL hold its previous value, underrun SHALL set to 1, and no pop SHALL occur.
REQ-021 When a push and a pop occur in the same cycle, level SHALL be unchanged and both SHALL take effect; there is no bypass, so a push into an empty FIFO on a tick cycle still counts as underrun.
REQ-022 underrun SHALL stay set until underrun_clr=1; when set and clear coincide, set SHALL win.
REQ-023 Deasserting enable SHALL force duty to the midpoint 2^(BIT_WIDTH-1) on the next edge; FIFO contents and level SHALL be retained, and pushes SHALL still be accepted.
REQ-024 A change of divider mid-period SHALL take effect immediately; if counter >= the new divider, a tick SHALL fire that cycle.
REQ-025 The first tick after enable rises SHALL occur divider+1 cycles after the first enabled cycle.

Reset
REQ-026 While rst_n=0, regardless of clk: pointers, level and counter SHALL be 0, duty SHALL be 2^(BIT_WIDTH-1), underrun SHALL be 0, and s_ready SHALL be 1.
REQ-027 When rst_n asserts mid-operation, buffered samples SHALL be discarded; operation SHALL resume on the first clk edge after rst_n deasserts.
REQ-028 FIFO storage RAM need not be reset; no output SHALL depend on unwritten entries.

Verification
REQ-029 Reset scenario: hold reset, then release with enable=0 -> duty=9'h080, level=0, s_ready=1, underrun=0.
REQ-030 Conversion scenario: with divider=3, push 8'h80, 8'h00, 8'h7F, then enable -> duty becomes 0, then 128, then 255, each change 4 cycles apart; level goes 3->0.
REQ-031 Fill scenario: with enable=0, push 16 samples -> s_ready=0 and level=16; a 17th offer is not accepted; enable then drains the samples in order.
REQ-032 Underrun scenario: with divider=1 and one sample pushed -> the second tick sets underrun, and duty holds the first converted value; underrun_clr=1 clears the flag unless another tick coincides.
REQ-033 Simultaneous push/pop scenario: with level=5, push on the tick cycle -> level stays 5 and ordering is preserved.
REQ-034 Mid-operation scenario: lowering divider from 100 to 2 while counter=50 gives an immediate tick; asserting rst_n low mid-stream gives level=0 and duty=midpoint asynchronously.
